// File: rtl/tc141_skidfifo.sv
// First-word-fall-through FIFO behind a non-stallable delay pipe: no write-ready,
// afull throttles the source early, and any dropped write latches a sticky ovfl.
module tc141_skidfifo #(
  parameter int DAT = 8,
  parameter int DEP = 8,
  parameter int AFL = DEP - 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_vld,
  input  logic [DAT-1:0]             wr_dat,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [DAT-1:0]             rd_dat,
  output logic                       afull,
  output logic                       ovfl,
  output logic [$clog2(DEP+1)-1:0]   lvl
);

  localparam int AW = $clog2(DEP);
  localparam int LW = $clog2(DEP + 1);

  logic [DAT-1:0] mem_q [DEP];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [LW-1:0]  lvl_q, lvl_d;
  logic           ovfl_q, ovfl_d;
  logic           push, pop;

  assign rd_vld = (lvl_q != '0);
  assign rd_dat = mem_q[rptr_q];
  assign afull  = (lvl_q >= LW'(AFL));
  assign ovfl   = ovfl_q;
  assign lvl    = lvl_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    pop    = rd_vld & rd_rdy;
    push   = wr_vld & ((lvl_q != LW'(DEP)) | pop);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    lvl_d  = lvl_q;
    ovfl_d = ovfl_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
    if (wr_vld && !push) ovfl_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
      ovfl_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      lvl_q  <= lvl_d;
      ovfl_q <= ovfl_d;
    end
  end

  // Storage is not reset; a write coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (push && !rstn) mem_q[wptr_q] <= wr_dat;
  end

endmodule

// File: tb/tb_tc141_skidfifo.sv
// Bench for tc141_skidfifo (DAT=8, DEP=4, AFL=3): vector table, directed
// corner sequences, and a randomized run against a queue-based model.
module tb_tc141_skidfifo;

  localparam int DEP = 4;
  localparam int AFL = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       wr_vld = 1'b0;
  logic [7:0] wr_dat = '0;
  logic       rd_rdy = 1'b0;
  logic       rd_vld;
  logic [7:0] rd_dat;
  logic       afull;
  logic       ovfl;
  logic [2:0] lvl;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  bit         mov = 1'b0;

  typedef struct {
    bit       rst;
    bit       wv;
    bit [7:0] wd;
    bit       rr;
    bit       vld;
    bit [7:0] dat;
    int       lv;
    bit       af;
    bit       ov;
  } vec_t;

  vec_t tbl[$];

  tc141_skidfifo #(.DAT(8), .DEP(DEP), .AFL(AFL)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .wr_vld (wr_vld),
    .wr_dat (wr_dat),
    .rd_rdy (rd_rdy),
    .rd_vld (rd_vld),
    .rd_dat (rd_dat),
    .afull  (afull),
    .ovfl   (ovfl),
    .lvl    (lvl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the reference queue by the FIFO rules,
  // then settle just after the edge so outputs can be sampled.
  task automatic cyc(input bit r, input bit wv, input bit [7:0] wd, input bit rr);
    bit mpop, mpush;
    rstn   = r;
    wr_vld = wv;
    wr_dat = wd;
    rd_rdy = rr;
    if (r) begin
      mq.delete();
      mov = 1'b0;
    end else begin
      mpop  = (mq.size() != 0) && rr;
      mpush = wv && ((mq.size() < DEP) || mpop);
      if (mpop) void'(mq.pop_front());
      if (mpush) mq.push_back(wd);
      if (wv && !mpush) mov = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_lvl"}, int'(lvl), mq.size());
    chk({tag, "_vld"}, int'(rd_vld), int'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, "_dat"}, int'(rd_dat), int'(mq[0]));
    chk({tag, "_afull"}, int'(afull), int'(mq.size() >= AFL));
    chk({tag, "_ovfl"}, int'(ovfl), int'(mov));
  endtask

  initial begin
    // rst wv wd rr | vld dat lvl afull ovfl
    tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{0, 1, 8'h11, 0, 1, 8'h11, 1, 0, 0});
    tbl.push_back('{0, 1, 8'h22, 0, 1, 8'h11, 2, 0, 0});
    tbl.push_back('{0, 1, 8'h33, 0, 1, 8'h11, 3, 1, 0});
    tbl.push_back('{0, 1, 8'h44, 0, 1, 8'h11, 4, 1, 0});
    tbl.push_back('{0, 1, 8'h55, 0, 1, 8'h11, 4, 1, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h22, 3, 1, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h33, 2, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h44, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 1, 8'hA5, 1, 1, 8'hA5, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 8'hA5, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 8'hA5, 1, 0, 1});
    tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].wv, tbl[i].wd, tbl[i].rr);
      chk($sformatf("t%0d_vld", i), int'(rd_vld), int'(tbl[i].vld));
      if (tbl[i].vld) chk($sformatf("t%0d_dat", i), int'(rd_dat), int'(tbl[i].dat));
      chk($sformatf("t%0d_lvl", i), int'(lvl), tbl[i].lv);
      chk($sformatf("t%0d_afull", i), int'(afull), int'(tbl[i].af));
      chk($sformatf("t%0d_ovfl", i), int'(ovfl), int'(tbl[i].ov));
    end

    // Full passthrough across pointer wrap: words 0..3 stored, then 4..11 streamed.
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'(i), 0);
    chk("pt_fill_lvl", int'(lvl), 4);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 8'(k + 4), 1);
      chk($sformatf("pt%0d_lvl", k), int'(lvl), 4);
      chk($sformatf("pt%0d_dat", k), int'(rd_dat), k + 1);
      chk($sformatf("pt%0d_ovfl", k), int'(ovfl), 0);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ptd%0d_dat", k), int'(rd_dat), k + 8);
      cyc(0, 0, 8'h00, 1);
    end
    chk("ptd_empty_vld", int'(rd_vld), 0);

    // Mid-operation reset with lvl=3 and ovfl set; the concurrent write is lost.
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'h60 + i), 0);
    cyc(0, 0, 8'h00, 1);
    chk("mr_pre_lvl", int'(lvl), 3);
    chk("mr_pre_ovfl", int'(ovfl), 1);
    cyc(1, 1, 8'h77, 1);
    chk("mr_lvl", int'(lvl), 0);
    chk("mr_ovfl", int'(ovfl), 0);
    chk("mr_vld", int'(rd_vld), 0);
    cyc(0, 0, 8'h00, 0);
    chk("mr_nostore_vld", int'(rd_vld), 0);
    chk("mr_nostore_lvl", int'(lvl), 0);
    cyc(0, 1, 8'h99, 0);
    chk("mr_first_vld", int'(rd_vld), 1);
    chk("mr_first_dat", int'(rd_dat), 8'h99);

    // Randomized traffic against the queue model, rates varied per segment.
    cyc(1, 0, 8'h00, 0);
    for (int s = 0; s < 10; s++) begin
      int unsigned wp, rp;
      wp = $urandom_range(10, 95);
      rp = $urandom_range(10, 95);
      for (int c = 0; c < 1000; c++) begin
        cyc(($urandom_range(0, 999) == 0), ($urandom_range(0, 99) < wp),
            8'($urandom), ($urandom_range(0, 99) < rp));
        chk_model($sformatf("rnd%0d_%0d", s, c));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
